// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Optional overflow counter is enabled by defining ADDER_ARB_OVF_COUNT_EN.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT,
        RESP
    } state_t;

    localparam int OVF_CNT_W = 16;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/adder_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping.
module adder_rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    int pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        pos       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[pos]) begin
                grant_any  = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/parameterized_adder.sv
// WIDTH-bit adder with carry in/out; optionally registers its result.
module parameterized_adder #(
    parameter int WIDTH           = 4,
    parameter int PIPELINE_ENABLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] total_p0;

    assign total_p0 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    generate
        if (PIPELINE_ENABLE != 0) begin : g_reg
            logic [WIDTH:0] total_p1;

            // stage p0 -> p1: registered sum
            always_ff @(posedge clk) begin
                if (rst) begin
                    total_p1 <= '0;
                end else begin
                    total_p1 <= total_p0;
                end
            end

            assign {cout, sum} = total_p1;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = clk ^ rst;
            assign {cout, sum}    = total_p0;
        end
    endgenerate

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder among NUM_REQ requesters, one op in flight.
// Define ADDER_ARB_OVF_COUNT_EN to add the ovf_count carry-out response counter.
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int NUM_REQ         = 4,
    parameter int PIPELINE_ENABLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]         req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout
`ifdef ADDER_ARB_OVF_COUNT_EN
    ,
    output logic [OVF_CNT_W-1:0]       ovf_count
`endif
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic              pick_any;
    logic              accept;
    logic              capture;

    logic [WIDTH-1:0]  a_p0, b_p0;
    logic              cin_p0;
    logic [ID_W-1:0]   id_p0;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;

    adder_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    parameterized_adder #(
        .WIDTH           (WIDTH),
        .PIPELINE_ENABLE (PIPELINE_ENABLE)
    ) u_adder (
        .clk  (clk),
        .rst  (rst),
        .a    (a_p0),
        .b    (b_p0),
        .cin  (cin_p0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept  = (state == IDLE) && pick_any && !rst;
    assign capture = (PIPELINE_ENABLE != 0) ? (state == WAIT) : (state == EXEC);

    // Reset masks the handshake outputs in the same cycle it is asserted.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        req_ready = pick_grant;
                        state_nxt = EXEC;
                    end
                end
                EXEC:    state_nxt = (PIPELINE_ENABLE != 0) ? WAIT : RESP;
                WAIT:    state_nxt = RESP;
                RESP: begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            end
            if (capture) begin
                rsp_id   <= id_p0;
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
            end
        end
    end

    // stage p0: operands of the granted requester held for the whole op
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
            b_p0   <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
            cin_p0 <= req_cin[pick_idx];
            id_p0  <= pick_idx;
        end
    end

`ifdef ADDER_ARB_OVF_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (state == RESP && rsp_ready && rsp_cout && ovf_count != '1) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a response scoreboard.
// Covers ADDER_ARB_OVF_COUNT_EN when that macro is defined.
module tb_adder_share_arbiter;

    localparam int W = 4;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] sum;
        logic         cout;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a     = '0;
    logic [N*W-1:0] req_b     = '0;
    logic [N-1:0]   req_cin   = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;

    logic [N-1:0]   req_valid_np = '0;
    logic [N-1:0]   req_ready_np;
    logic [N*W-1:0] req_a_np     = '0;
    logic [N*W-1:0] req_b_np     = '0;
    logic [N-1:0]   req_cin_np   = '0;
    logic           rsp_valid_np;
    logic           rsp_ready_np = 1'b0;
    logic [1:0]     rsp_id_np;
    logic [W-1:0]   rsp_sum_np;
    logic           rsp_cout_np;

`ifdef ADDER_ARB_OVF_COUNT_EN
    logic [15:0] ovf_count;
    logic [15:0] ovf_count_np;
`endif

    adder_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .PIPELINE_ENABLE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef ADDER_ARB_OVF_COUNT_EN
        , .ovf_count(ovf_count)
`endif
    );

    adder_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .PIPELINE_ENABLE(0)) dut_np (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_np), .req_ready(req_ready_np),
        .req_a(req_a_np), .req_b(req_b_np), .req_cin(req_cin_np),
        .rsp_valid(rsp_valid_np), .rsp_ready(rsp_ready_np),
        .rsp_id(rsp_id_np), .rsp_sum(rsp_sum_np), .rsp_cout(rsp_cout_np)
`ifdef ADDER_ARB_OVF_COUNT_EN
        , .ovf_count(ovf_count_np)
`endif
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_state  = 0;
    int   m_ptr    = 0;
    int   m_ovf    = 0;
    int   grants[$];
    rsp_t sb[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input int a, input int b, input int c);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        req_cin[i]      = c[0];
    endtask

    // Mid-cycle check of the pipelined DUT against the model, then advance one clock.
    task automatic tick();
        int         g;
        rsp_t       e;
        logic [W:0] full;
        @(negedge clk);
        if (rst) begin
            check("ready_in_rst", req_ready, 0);
            check("rsp_valid_in_rst", rsp_valid, 0);
            m_state = 0;
            m_ptr   = 0;
            m_ovf   = 0;
            sb.delete();
        end else begin
            case (m_state)
                0: begin
                    check("rsp_valid_idle", rsp_valid, 0);
                    g = pick(req_valid, m_ptr);
                    if (g < 0) begin
                        check("ready_no_req", req_ready, 0);
                    end else begin
                        check("grant", req_ready, 32'(1 << g));
                        full = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]}
                             + {{W{1'b0}}, req_cin[g]};
                        e.id   = 2'(g);
                        e.sum  = full[W-1:0];
                        e.cout = full[W];
                        sb.push_back(e);
                        grants.push_back(g);
                        m_ptr   = (g + 1) % N;
                        m_state = 1;
                    end
                end
                1, 2: begin
                    check("ready_busy", req_ready, 0);
                    check("rsp_valid_busy", rsp_valid, 0);
                    m_state = m_state + 1;
                end
                default: begin
                    check("ready_resp", req_ready, 0);
                    check("rsp_valid_resp", rsp_valid, 1);
                    check("sb_nonempty", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        check("rsp_id", rsp_id, sb[0].id);
                        check("rsp_sum", rsp_sum, sb[0].sum);
                        check("rsp_cout", rsp_cout, sb[0].cout);
                        if (rsp_ready) begin
                            if (sb[0].cout) m_ovf++;
                            void'(sb.pop_front());
                            m_state = 0;
                        end
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with every requester asking
        req_valid = '1;
        tick();
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_cout", rsp_cout, 0);

        // Single requester 2: 9 + 12 + 1
        set_op(2, 9, 12, 1);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        tick();
        check("t2_rsp_valid", rsp_valid, 1);
        check("t2_id", rsp_id, 2);
        check("t2_sum", rsp_sum, 4'b0110);
        check("t2_cout", rsp_cout, 1);
        tick();
        tick();

        // All requesters held valid: fair rotation from pointer 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, i * 3 + 7, 5 + i * 2, i % 2);
        grants.delete();
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (20) tick();
        req_valid = '0;
        check("t3_grant_count", grants.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grants.size()) check($sformatf("t3_grant%0d", k), grants[k], exp_order[k]);
        end

        // Back-pressure on the response channel
        set_op(0, 6, 11, 1);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = '1;
        tick();
        tick();
        repeat (5) tick();
        rsp_ready = 1'b1;
        req_valid = '0;
        tick();
        tick();
        check("t4_sb_drained", sb.size(), 0);

        // Reset while the pipelined adder is in WAIT
        set_op(3, 5, 5, 0);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        req_valid = '1;
        tick();
        check("t5_grant_after_rst", grants[grants.size()-1], 0);
        req_valid = '0;
        repeat (3) tick();

        // Combinational adder instance, requester 1: 3 + 10 + 0
        req_a_np[1*W +: W] = 4'd3;
        req_b_np[1*W +: W] = 4'd10;
        req_cin_np[1]      = 1'b0;
        req_valid_np       = 4'b0010;
        rsp_ready_np       = 1'b1;
        #1;
        check("t6_grant", req_ready_np, 4'b0010);
        check("t6_rsp_valid_acc", rsp_valid_np, 0);
        tick();
        req_valid_np = '0;
        #1;
        check("t6_rsp_valid_exec", rsp_valid_np, 0);
        tick();
        check("t6_rsp_valid", rsp_valid_np, 1);
        check("t6_id", rsp_id_np, 1);
        check("t6_sum", rsp_sum_np, 4'b1101);
        check("t6_cout", rsp_cout_np, 0);
        tick();
        check("t6_rsp_done", rsp_valid_np, 0);

`ifdef ADDER_ARB_OVF_COUNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_after_rst", ovf_count, 0);
        set_op(1, 15, 1, 0);
        rsp_ready = 1'b1;
        repeat (3) begin
            req_valid = 4'b0010;
            tick();
            req_valid = '0;
            repeat (3) tick();
        end
        check("ovf_model", ovf_count, m_ovf);
        check("ovf_three", ovf_count, 3);
        check("ovf_np_zero", ovf_count_np, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
